vga_upscale_2x: RTL
===================

// Module: vga_upscale_2x
// PURPOSE
// - Avalon-ST pixel-stream stage sitting between the 320x240 face/edge pixel source and the 640x480 VGA output module.
// - Buffers one input line, then replays it as two output lines with each pixel doubled (nearest-neighbour 2x).
// - Locks to the input start-of-frame, regenerates output sop/eop for the 640x480 frame and flags malformed input frames.
// PARAMETERS
// - IN_W   320  input pixels per line; output line = 2*IN_W
// - IN_H   240  input lines per frame; output frame = 2*IN_H lines
// - DW     30   pixel width ({R8,2'b0,G8,2'b0,B8,2'b0})
// PORTS
// - clk        in   1   clock
// - reset      in   1   synchronous, active-high reset
// - in_data    in   DW  input pixel
// - in_sop     in   1   input start of frame (pixel 0,0)
// - in_eop     in   1   input end of frame (pixel IN_W-1,IN_H-1)
// - in_valid   in   1   input pixel valid
// - in_ready   out  1   block accepts input pixel this cycle
// - out_data   out  DW  output pixel
// - out_sop    out  1   output start of frame (pixel 0,0)
// - out_eop    out  1   output end of frame (pixel 2*IN_W-1,2*IN_H-1)
// - out_valid  out  1   output pixel valid
// - out_ready  in   1   downstream accepts output pixel
// - frame_err  out  1   one-cycle pulse on malformed input frame
// BEHAVIOUR
// - Reset: state=SYNC, all counters 0, in_ready=0, out_valid=0, out_sop=0, out_eop=0, frame_err=0, out_data=0.
// - Transfer = valid & ready in the same cycle, on either side.
// - Line buffer: IN_W x DW, synchronous (registered) read, one write port; infers block RAM.
// - States:
//   SYNC : in_ready=1; input beats without in_sop are dropped; beat with in_sop is written to buf[0], in_col=1 -> LOAD.
//   LOAD : in_ready=1; each beat written to buf[in_col], in_col++; beat at in_col=IN_W-1 -> EMIT, rep=0, out_col=0.
//   EMIT : in_ready=0; streams 2*IN_W pixels, out_data=buf[out_col>>1]; after last pixel: rep=0 -> rep=1, replay line;
//          rep=1 -> in_row++ and LOAD (in_row wraps IN_H-1 -> 0, out_row likewise wraps 2*IN_H-1 -> 0).
// - Output: first out_valid exactly 2 cycles after the beat that completes a line (RAM read + output register).
// - out_valid/out_data/out_sop/out_eop held stable while out_valid & ~out_ready; next pixel presented the cycle after a
//   transfer (full throughput, 1 pixel/clk when out_ready=1).
// - out_sop=1 only with out_row=0,out_col=0; out_eop=1 only with out_row=2*IN_H-1,out_col=2*IN_W-1.
// - Counters: in_col 0..IN_W-1, in_row 0..IN_H-1, out_col 0..2*IN_W-1, out_row 0..2*IN_H-1; widths $clog2 of range.
// - Input framing checks (LOAD only):
//   in_eop on a beat not at (IN_W-1,IN_H-1): frame_err pulse, beat written, -> SYNC after this line's EMIT completes.
//   (IN_W-1,IN_H-1) beat without in_eop: frame_err pulse, frame still emitted normally.
//   in_sop on a beat not at (0,0): see CONFIGURATION.
// - Reset mid-frame: outputs return to reset values next cycle; partial output frame abandoned (no eop); relock via SYNC.
// - frame_err and a state transition in the same cycle are independent; pulse is never longer than one cycle.
// CONFIGURATION
// - UPSCALE_RESYNC_EN defined: unexpected in_sop in LOAD -> frame_err pulse, beat written to buf[0], in_col=1, in_row=0,
//   out_row=0 (next emitted line starts a new output frame with out_sop).
// - UPSCALE_RESYNC_EN undefined: unexpected in_sop -> frame_err pulse only; beat treated as ordinary pixel, counters kept.
// TESTING
// - Reset, then 3 beats without sop, then a full frame with sop -> pre-sop beats dropped, in_ready=1 throughout SYNC.
// - Frame with pixel value = column index, out_ready=1 -> output row 0 = 0,0,1,1,...,319,319; row 1 identical; 307200
//   beats total, out_sop on beat 0 only, out_eop on beat 307199 only; first out_valid 2 cycles after 320th input beat.
// - Random out_ready (50%) -> out_data/sop/eop stable while stalled, output sequence bit-identical to ready=1 run.
// - in_eop at line 10 col 319 -> frame_err=1 for exactly one cycle, lines 10 emitted twice, then SYNC (in_ready=1, drop).
// - in_sop at line 5 col 100: with UPSCALE_RESYNC_EN -> frame_err pulse, next output line has out_sop; without -> pulse,
//   out_sop absent, frame count unaffected.
// - reset asserted mid EMIT (out_col=200) -> next cycle out_valid=0, in_ready=0; after release, resync on next in_sop.

Source files
------------

// File: rtl/vga_upscale_2x.sv
// vga_upscale_2x: nearest-neighbour 2x upscaler between Avalon-ST pixel streams.
// Buffers one input line, replays it as two doubled output lines, regenerates
// 640x480 sop/eop and pulses frame_err on malformed input framing.
// Ports: clk, reset (sync, active-high);
//   sink   in_data/in_sop/in_eop/in_valid -> in_ready;
//   source out_data/out_sop/out_eop/out_valid <- out_ready;
//   frame_err one-cycle error pulse.
// Option: define UPSCALE_RESYNC_EN to restart the frame on an unexpected in_sop.
module vga_upscale_2x #(
  parameter int IN_W = 320,
  parameter int IN_H = 240,
  parameter int DW   = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_err
);

  localparam int CW  = $clog2(IN_W);
  localparam int RW  = $clog2(IN_H);
  localparam int OCW = $clog2(2 * IN_W);
  localparam int ORW = $clog2(2 * IN_H);

  localparam logic [CW-1:0]  COL_LAST  = CW'(IN_W - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(IN_H - 1);
  localparam logic [OCW-1:0] OCOL_LAST = OCW'(2 * IN_W - 1);
  localparam logic [ORW-1:0] OROW_LAST = ORW'(2 * IN_H - 1);

  typedef enum logic [1:0] {
    SYNC,
    LOAD,
    EMIT
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  in_col, in_col_n;
  logic [RW-1:0]  in_row, in_row_n;
  logic [OCW-1:0] out_col, out_col_n;
  logic [ORW-1:0] out_row, out_row_n;
  logic           rep, rep_n;
  logic           eop_pend, eop_pend_n;

  logic [DW-1:0]  line_buf [IN_W];
  logic           wr_en;
  logic [CW-1:0]  wr_addr;
  logic           err;
  logic           resync;
  logic           in_fire;
  logic           fetch;
  logic           at_first;
  logic           at_last;

  assign in_fire  = in_valid & in_ready;
  assign fetch    = (state == EMIT) &
                    (~out_valid | out_ready);
  assign at_first = (in_col == '0) &
                    (in_row == '0);
  assign at_last  = (in_col == COL_LAST) &
                    (in_row == ROW_LAST);

  always_comb begin
    state_n    = state;
    in_col_n   = in_col;
    in_row_n   = in_row;
    out_col_n  = out_col;
    out_row_n  = out_row;
    rep_n      = rep;
    eop_pend_n = eop_pend;
    wr_en      = 1'b0;
    wr_addr    = in_col;
    err        = 1'b0;
    resync     = 1'b0;
    unique case (state)
      SYNC: begin
        if (in_fire & in_sop) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          in_col_n   = CW'(1);
          in_row_n   = '0;
          out_row_n  = '0;
          eop_pend_n = 1'b0;
          state_n    = LOAD;
        end
      end
      LOAD: begin
        if (in_fire) begin
          wr_en = 1'b1;
          if (in_eop & ~at_last) begin
            err        = 1'b1;
            eop_pend_n = 1'b1;
          end
          if (at_last & ~in_eop)
            err = 1'b1;
          if (in_sop & ~at_first) begin
            err = 1'b1;
`ifdef UPSCALE_RESYNC_EN
            resync = 1'b1;
`endif
          end
          if (resync) begin
            wr_addr    = '0;
            in_col_n   = CW'(1);
            in_row_n   = '0;
            out_row_n  = '0;
            eop_pend_n = 1'b0;
          end else if (in_col == COL_LAST) begin
            in_col_n  = '0;
            out_col_n = '0;
            rep_n     = 1'b0;
            state_n   = EMIT;
          end else begin
            in_col_n = in_col + 1'b1;
          end
        end
      end
      EMIT: begin
        if (fetch) begin
          if (out_col == OCOL_LAST) begin
            out_col_n = '0;
            out_row_n = (out_row == OROW_LAST) ?
                        '0 : out_row + 1'b1;
            if (rep) begin
              rep_n      = 1'b0;
              in_row_n   = (in_row == ROW_LAST) ?
                           '0 : in_row + 1'b1;
              eop_pend_n = 1'b0;
              state_n    = eop_pend ? SYNC : LOAD;
            end else begin
              rep_n = 1'b1;
            end
          end else begin
            out_col_n = out_col + 1'b1;
          end
        end
      end
      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SYNC;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      rep       <= 1'b0;
      eop_pend  <= 1'b0;
      in_ready  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      in_col    <= in_col_n;
      in_row    <= in_row_n;
      out_col   <= out_col_n;
      out_row   <= out_row_n;
      rep       <= rep_n;
      eop_pend  <= eop_pend_n;
      in_ready  <= (state_n != EMIT);
      frame_err <= err & ~frame_err;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      line_buf[wr_addr] <= in_data;
  end

  // The RAM output register doubles as the
  // output stage; it only advances on fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (fetch) begin
      out_data  <= line_buf[out_col[OCW-1:1]];
      out_valid <= 1'b1;
      out_sop   <= (out_row == '0) &
                   (out_col == '0);
      out_eop   <= (out_row == OROW_LAST) &
                   (out_col == OCOL_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
